multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control FSM for the multicycle CPU. It decodes the instruction-register fields and sequences each instruction through fetch, decode, execute, memory and write-back states. It drives every datapath enable and mux select, including the register file write port (RegWrite, destination select, write-data select) and the A/B operand latches fed by the register file read ports.

## Interface
Parameters: none; opcode/funct encodings fixed (MIPS subset below).
- Clk  in  1  clock, all state changes on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Opcode  in  6  IR[31:26], stable from DECODE until next FETCH
- Funct  in  6  IR[5:0]
- Zero  in  1  ALU zero flag, same-cycle
- PCWrite, IRWrite, ABWrite, MemWrite, RegWrite  out  1 each  write enables
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- ALUSrcA  out  1  0 = PC, 1 = A
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = extended imm, 11 = sign-ext imm<<2
- ExtZero  out  1  1 = zero-extend imm (XORI), else sign-extend
- ALUOp  out  3  000 ADD, 001 SUB, 010 XOR, 011 SLT
- PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = A
- RegDst  out  2  00 = rt, 01 = rd, 10 = $31
- MemToReg  out  2  00 = ALUOut, 01 = MDR, 10 = PC
- InstrDone  out  1  high during final state of each instruction
- IllegalOp  out  1  high in DECODE for unsupported opcode/funct
- State  out  4  current state, for debug/bench

## Operation
- Supported: R-type (op 0x00) ADD 0x20, SUB 0x22, SLT 0x2A, JR 0x08; ADDI 0x08, XORI 0x0E, LW 0x23, SW 0x2B, BNE 0x05, J 0x02, JAL 0x03.
- States, with encoding: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, MEM_ADDR 4, MEM_READ 5, MEM_WRITE 6, WB_ALU 7, WB_MEM 8, BRANCH 9, JUMP 10, JAL 11, JR 12. Codes 13-15 return to FETCH.
- Only the state is registered. Outputs decode combinationally from State, Opcode, Funct and Zero. Any output not listed for a state is 0.
- FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSrc=00, PCWrite=1. Next state is DECODE.
- DECODE: ABWrite=1, ALUSrcA=0, ALUSrcB=11, ALUOp=ADD (branch target to ALUOut). Next state:
  - R ADD/SUB/SLT goes to EXEC_R; JR goes to JR.
  - ADDI/XORI go to EXEC_I; LW/SW go to MEM_ADDR.
  - BNE goes to BRANCH, J to JUMP, JAL to JAL.
  - Anything else goes to FETCH, with IllegalOp=1 and InstrDone=1.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp from Funct. Next state is WB_ALU.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp ADD (ADDI) or XOR (XORI); ExtZero=1 for XORI. Next state is WB_ALU.
- WB_ALU: RegWrite=1, MemToReg=00, RegDst=01 if Opcode==0 else 00. InstrDone=1. Next state is FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD. Next state is MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ: IorD=1 (MDR captures). Next state is WB_MEM.
- WB_MEM: RegWrite=1, RegDst=00, MemToReg=01. InstrDone=1. Next state is FETCH.
- MEM_WRITE: IorD=1, MemWrite=1. InstrDone=1. Next state is FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCSrc=01, PCWrite=~Zero. InstrDone=1. Next state is FETCH.
- JUMP: PCSrc=10, PCWrite=1. InstrDone=1. Next state is FETCH.
- JAL: PCSrc=10, PCWrite=1, RegWrite=1, RegDst=10, MemToReg=10. The old PC (already PC+4) is written to $31 in the same edge as the PC update. InstrDone=1. Next state is FETCH.
- JR: PCSrc=11, PCWrite=1. InstrDone=1. Next state is FETCH.
- Writes to $0 are issued normally; the register file discards them.

## Timing
- Reset: Reset_n=0 forces State=FETCH immediately, without waiting for a clock.
  - While Reset_n=0, PCWrite, IRWrite, ABWrite, MemWrite and RegWrite are forced to 0 and IllegalOp/InstrDone to 0.
  - Selects show FETCH values.
  - The first rising edge after release performs FETCH.
- Reset mid-instruction: the instruction is abandoned and no enable is asserted after Reset_n falls.
- Cycles per instruction:
  - R-type, ADDI, XORI: 4.
  - LW: 5.
  - SW: 4.
  - BNE, J, JAL, JR: 3.
  - Illegal: 2.
- Zero is sampled combinationally in BRANCH only.
- Opcode/Funct changes outside DECODE..final state have no effect.

## Test plan
- Reset held 3 cycles mid-LW (State=5) -> State=0 asynchronously, all enables 0. After release: FETCH, then DECODE on the next edge.
- ADD (op 0, funct 0x20) -> States 0,1,2,7,0. In state 7: RegWrite=1, RegDst=01, InstrDone=1. ALUOp=000 in state 2.
- LW then SW -> LW states 0,1,4,5,8 (WB_MEM: MemToReg=01, RegDst=00). SW states 0,1,4,6 with MemWrite=1 only in 6.
- BNE with Zero=1 then Zero=0 -> States 0,1,9 both times. PCWrite=0 then 1; PCSrc=01, ALUOp=SUB.
- JAL, then JR -> JAL state 11: PCWrite=1, RegWrite=1, RegDst=10, MemToReg=10. JR state 12: PCSrc=11, PCWrite=1.
- Opcode 0x3F and R-type funct 0x00 -> DECODE shows IllegalOp=1, InstrDone=1, then FETCH. No RegWrite/MemWrite pulse.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle CPU controller and its datapath.
// The master side (the controller) receives the instruction fields and the
// ALU zero flag, and drives every datapath enable/select plus the debug
// state code. The slave side is the datapath view of the same signals.
interface multicycle_control_if;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic       PCWrite, IRWrite, ABWrite, MemWrite, RegWrite;
  logic       IorD;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       ExtZero;
  logic [2:0] ALUOp;
  logic [1:0] PCSrc;
  logic [1:0] RegDst;
  logic [1:0] MemToReg;
  logic       InstrDone;
  logic       IllegalOp;
  logic [3:0] State;

  modport master (
    input  Opcode, Funct, Zero,
    output PCWrite, IRWrite, ABWrite, MemWrite, RegWrite, IorD, ALUSrcA,
           ALUSrcB, ExtZero, ALUOp, PCSrc, RegDst, MemToReg, InstrDone,
           IllegalOp, State
  );

  modport slave (
    output Opcode, Funct, Zero,
    input  PCWrite, IRWrite, ABWrite, MemWrite, RegWrite, IorD, ALUSrcA,
           ALUSrcB, ExtZero, ALUOp, PCSrc, RegDst, MemToReg, InstrDone,
           IllegalOp, State
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle CPU (MIPS subset).
// Ports:
//   Clk     - clock, state advances on the rising edge
//   Reset_n - asynchronous active-low reset, forces FETCH and kills enables
//   bus     - master side of multicycle_control_if: Opcode/Funct/Zero in,
//             datapath enables, mux selects, InstrDone/IllegalOp/State out.
// Only the state is registered; every output decodes combinationally from
// the state, Opcode, Funct and Zero.
module multicycle_control (
  input  logic                       Clk,
  input  logic                       Reset_n,
  multicycle_control_if.master       bus
);
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,  S_DECODE   = 4'd1,  S_EXEC_R  = 4'd2,
    S_EXEC_I    = 4'd3,  S_MEM_ADDR = 4'd4,  S_MEM_READ = 4'd5,
    S_MEM_WRITE = 4'd6,  S_WB_ALU   = 4'd7,  S_WB_MEM  = 4'd8,
    S_BRANCH    = 4'd9,  S_JUMP     = 4'd10, S_JAL     = 4'd11,
    S_JR        = 4'd12
  } state_e;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_XORI = 6'h0E,
                         OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_JR = 6'h08, FN_ADD = 6'h20, FN_SUB = 6'h22,
                         FN_SLT = 6'h2A;
  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001,
                         ALU_XOR = 3'b010, ALU_SLT = 3'b011;

  state_e state_q, state_d;

  logic       pc_write, ir_write, ab_write, mem_write, reg_write;
  logic       iord, alu_src_a, ext_zero, instr_done, illegal_op;
  logic [1:0] alu_src_b, pc_src, reg_dst, mem_to_reg;
  logic [2:0] alu_op;

  logic is_r, r_alu, r_jr;
  assign is_r  = (bus.Opcode == OP_R);
  assign r_alu = is_r && (bus.Funct == FN_ADD || bus.Funct == FN_SUB ||
                          bus.Funct == FN_SLT);
  assign r_jr  = is_r && (bus.Funct == FN_JR);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    ab_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    iord       = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    ext_zero   = 1'b0;
    alu_op     = ALU_ADD;
    pc_src     = 2'b00;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is computed speculatively into ALUOut here.
        ab_write  = 1'b1;
        alu_src_b = 2'b11;
        if (r_alu)     state_d = S_EXEC_R;
        else if (r_jr) state_d = S_JR;
        else begin
          case (bus.Opcode)
            OP_ADDI, OP_XORI: state_d = S_EXEC_I;
            OP_LW, OP_SW:     state_d = S_MEM_ADDR;
            OP_BNE:           state_d = S_BRANCH;
            OP_J:             state_d = S_JUMP;
            OP_JAL:           state_d = S_JAL;
            default: begin
              // Also catches R-type with an unsupported funct.
              illegal_op = 1'b1;
              instr_done = 1'b1;
              state_d    = S_FETCH;
            end
          endcase
        end
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        case (bus.Funct)
          FN_SUB:  alu_op = ALU_SUB;
          FN_SLT:  alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
        state_d = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (bus.Opcode == OP_XORI) begin
          alu_op   = ALU_XOR;
          ext_zero = 1'b1;
        end
        state_d = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_write  = 1'b1;
        reg_dst    = is_r ? 2'b01 : 2'b00;
        instr_done = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (bus.Opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        iord    = 1'b1;
        state_d = S_WB_MEM;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_src     = 2'b01;
        pc_write   = ~bus.Zero;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      S_JAL: begin
        // PC already holds PC+4, so it is the link value written to $31.
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
        instr_done = 1'b1;
      end
      S_JR: begin
        pc_src     = 2'b11;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Enables and status are gated by reset so nothing fires while it is held;
  // selects already show FETCH values because the state resets asynchronously.
  assign bus.PCWrite   = pc_write   & Reset_n;
  assign bus.IRWrite   = ir_write   & Reset_n;
  assign bus.ABWrite   = ab_write   & Reset_n;
  assign bus.MemWrite  = mem_write  & Reset_n;
  assign bus.RegWrite  = reg_write  & Reset_n;
  assign bus.InstrDone = instr_done & Reset_n;
  assign bus.IllegalOp = illegal_op & Reset_n;
  assign bus.IorD      = iord;
  assign bus.ALUSrcA   = alu_src_a;
  assign bus.ALUSrcB   = alu_src_b;
  assign bus.ExtZero   = ext_zero;
  assign bus.ALUOp     = alu_op;
  assign bus.PCSrc     = pc_src;
  assign bus.RegDst    = reg_dst;
  assign bus.MemToReg  = mem_to_reg;
  assign bus.State     = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  multicycle_control_if bus();
  multicycle_control dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));

  // {PCWrite,IRWrite,ABWrite,MemWrite,RegWrite,IorD,ALUSrcA,ALUSrcB,ExtZero,
  //  ALUOp,PCSrc,RegDst,MemToReg,InstrDone,IllegalOp}
  logic [20:0] act_w;
  assign act_w = {bus.PCWrite, bus.IRWrite, bus.ABWrite, bus.MemWrite,
                  bus.RegWrite, bus.IorD, bus.ALUSrcA, bus.ALUSrcB,
                  bus.ExtZero, bus.ALUOp, bus.PCSrc, bus.RegDst,
                  bus.MemToReg, bus.InstrDone, bus.IllegalOp};

  function automatic logic [20:0] cw(logic pcw, logic irw, logic abw,
      logic mw, logic rw, logic iord, logic srca, logic [1:0] srcb,
      logic ext, logic [2:0] aop, logic [1:0] pcs, logic [1:0] rd,
      logic [1:0] m2r, logic done, logic ill);
    return {pcw, irw, abw, mw, rw, iord, srca, srcb, ext, aop, pcs, rd,
            m2r, done, ill};
  endfunction

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic [3:0]  st;
    logic [20:0] w;
  } vec_t;
  vec_t vq[$];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  logic [20:0] F_W, D_W, WBR, WBI, EXI_A, EXI_X, MR, WBM, MW, JU, JA, JRW, DI;

  task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input logic [3:0] st, input logic [20:0] w);
    vq.push_back('{op: op, fn: fn, z: z, st: st, w: w});
  endtask

  task automatic pre(input logic [5:0] op, input logic [5:0] fn);
    add(op, fn, 1'b0, 4'd0, F_W);
    add(op, fn, 1'b0, 4'd1, D_W);
  endtask

  function automatic logic [20:0] exr(logic [2:0] aop);
    return cw(0,0,0,0,0, 0,1,2'b00,0,aop,2'b00,2'b00,2'b00,0,0);
  endfunction

  function automatic logic [20:0] br(logic z);
    return cw(~z,0,0,0,0, 0,1,2'b00,0,3'b001,2'b01,2'b00,2'b00,1,0);
  endfunction

  // Random-test reference: per-instruction state walk and which enables fire.
  typedef enum int {K_ADD, K_SUB, K_SLT, K_JR, K_ADDI, K_XORI, K_LW, K_SW,
                    K_BNE, K_J, K_JAL, K_ILL} kind_e;

  function automatic bit is_legal(logic [5:0] op, logic [5:0] fn);
    if (op == 6'h00) return fn inside {6'h20, 6'h22, 6'h2A, 6'h08};
    return op inside {6'h08, 6'h0E, 6'h23, 6'h2B, 6'h05, 6'h02, 6'h03};
  endfunction

  logic [20:0] enmask;

  initial begin
    F_W   = cw(1,1,0,0,0, 0,0,2'b01,0,3'b000,2'b00,2'b00,2'b00,0,0);
    D_W   = cw(0,0,1,0,0, 0,0,2'b11,0,3'b000,2'b00,2'b00,2'b00,0,0);
    WBR   = cw(0,0,0,0,1, 0,0,2'b00,0,3'b000,2'b00,2'b01,2'b00,1,0);
    WBI   = cw(0,0,0,0,1, 0,0,2'b00,0,3'b000,2'b00,2'b00,2'b00,1,0);
    EXI_A = cw(0,0,0,0,0, 0,1,2'b10,0,3'b000,2'b00,2'b00,2'b00,0,0);
    EXI_X = cw(0,0,0,0,0, 0,1,2'b10,1,3'b010,2'b00,2'b00,2'b00,0,0);
    MR    = cw(0,0,0,0,0, 1,0,2'b00,0,3'b000,2'b00,2'b00,2'b00,0,0);
    WBM   = cw(0,0,0,0,1, 0,0,2'b00,0,3'b000,2'b00,2'b00,2'b01,1,0);
    MW    = cw(0,0,0,1,0, 1,0,2'b00,0,3'b000,2'b00,2'b00,2'b00,1,0);
    JU    = cw(1,0,0,0,0, 0,0,2'b00,0,3'b000,2'b10,2'b00,2'b00,1,0);
    JA    = cw(1,0,0,0,1, 0,0,2'b00,0,3'b000,2'b10,2'b10,2'b10,1,0);
    JRW   = cw(1,0,0,0,0, 0,0,2'b00,0,3'b000,2'b11,2'b00,2'b00,1,0);
    DI    = cw(0,0,1,0,0, 0,0,2'b11,0,3'b000,2'b00,2'b00,2'b00,1,1);
    enmask = cw(1,1,1,1,1, 0,0,2'b00,0,3'b000,2'b00,2'b00,2'b00,1,1);

    // ---- vector table ----
    pre(6'h00, 6'h20); add(6'h00, 6'h20, 0, 4'd2, exr(3'b000)); add(6'h00, 6'h20, 0, 4'd7, WBR);
    pre(6'h00, 6'h22); add(6'h00, 6'h22, 0, 4'd2, exr(3'b001)); add(6'h00, 6'h22, 0, 4'd7, WBR);
    pre(6'h00, 6'h2A); add(6'h00, 6'h2A, 0, 4'd2, exr(3'b011)); add(6'h00, 6'h2A, 0, 4'd7, WBR);
    pre(6'h08, 6'h15); add(6'h08, 6'h15, 0, 4'd3, EXI_A); add(6'h08, 6'h15, 0, 4'd7, WBI);
    pre(6'h0E, 6'h00); add(6'h0E, 6'h00, 0, 4'd3, EXI_X); add(6'h0E, 6'h00, 0, 4'd7, WBI);
    pre(6'h23, 6'h00); add(6'h23, 6'h00, 0, 4'd4, EXI_A); add(6'h23, 6'h00, 0, 4'd5, MR);
    add(6'h23, 6'h00, 0, 4'd8, WBM);
    pre(6'h2B, 6'h00); add(6'h2B, 6'h00, 0, 4'd4, EXI_A); add(6'h2B, 6'h00, 0, 4'd6, MW);
    pre(6'h05, 6'h00); add(6'h05, 6'h00, 1, 4'd9, br(1'b1));
    pre(6'h05, 6'h00); add(6'h05, 6'h00, 0, 4'd9, br(1'b0));
    pre(6'h02, 6'h00); add(6'h02, 6'h00, 0, 4'd10, JU);
    pre(6'h03, 6'h00); add(6'h03, 6'h00, 0, 4'd11, JA);
    pre(6'h00, 6'h08); add(6'h00, 6'h08, 0, 4'd12, JRW);
    add(6'h3F, 6'h00, 0, 4'd0, F_W); add(6'h3F, 6'h00, 0, 4'd1, DI);
    add(6'h00, 6'h00, 0, 4'd0, F_W); add(6'h00, 6'h00, 0, 4'd1, DI);

    bus.Opcode = 6'h00; bus.Funct = 6'h00; bus.Zero = 1'b0;

    // ---- reset state ----
    #3;
    chk("reset_state", 32'(bus.State), 32'd0);
    chk("reset_outputs", 32'(act_w), 32'(F_W & ~enmask));
    @(negedge Clk); @(negedge Clk);
    Reset_n = 1'b1;

    // ---- table walk ----
    foreach (vq[i]) begin
      bus.Opcode = vq[i].op; bus.Funct = vq[i].fn; bus.Zero = vq[i].z;
      #1;
      chk($sformatf("vec%0d_state", i), 32'(bus.State), 32'(vq[i].st));
      chk($sformatf("vec%0d_ctrl", i), 32'(act_w), 32'(vq[i].w));
      @(posedge Clk); #1;
    end
    chk("after_illegal_fetch", 32'(bus.State), 32'd0);

    // ---- reset held mid-LW ----
    bus.Opcode = 6'h23; bus.Funct = 6'h00;
    repeat (3) begin @(posedge Clk); #1; end
    chk("lw_mem_read", 32'(bus.State), 32'd5);
    #2 Reset_n = 1'b0;
    #1;
    chk("async_reset_state", 32'(bus.State), 32'd0);
    chk("async_reset_ctrl", 32'(act_w), 32'(F_W & ~enmask));
    repeat (3) begin
      @(posedge Clk); #1;
      chk("held_reset_state", 32'(bus.State), 32'd0);
      chk("held_reset_en", 32'(act_w & enmask), 32'd0);
    end
    @(negedge Clk); Reset_n = 1'b1; #1;
    chk("release_fetch", 32'(act_w), 32'(F_W));
    @(posedge Clk); #1;
    chk("release_decode", 32'(bus.State), 32'd1);
    @(posedge Clk); #1;  // DECODE of LW -> MEM_ADDR
    chk("release_lw_addr", 32'(bus.State), 32'd4);
    repeat (2) begin @(posedge Clk); #1; end
    @(posedge Clk); #1;
    chk("release_lw_done", 32'(bus.State), 32'd0);

    // ---- randomized instruction stream vs reference model ----
    for (int n = 0; n < 150; n++) begin
      kind_e k;
      logic [5:0] op, fn;
      int sq[$];
      bit wr_reg;
      k = kind_e'($urandom_range(0, 11));
      fn = 6'($urandom_range(0, 63));
      case (k)
        K_ADD:  begin op = 6'h00; fn = 6'h20; sq = {0,1,2,7}; end
        K_SUB:  begin op = 6'h00; fn = 6'h22; sq = {0,1,2,7}; end
        K_SLT:  begin op = 6'h00; fn = 6'h2A; sq = {0,1,2,7}; end
        K_JR:   begin op = 6'h00; fn = 6'h08; sq = {0,1,12}; end
        K_ADDI: begin op = 6'h08; sq = {0,1,3,7}; end
        K_XORI: begin op = 6'h0E; sq = {0,1,3,7}; end
        K_LW:   begin op = 6'h23; sq = {0,1,4,5,8}; end
        K_SW:   begin op = 6'h2B; sq = {0,1,4,6}; end
        K_BNE:  begin op = 6'h05; sq = {0,1,9}; end
        K_J:    begin op = 6'h02; sq = {0,1,10}; end
        K_JAL:  begin op = 6'h03; sq = {0,1,11}; end
        default: begin
          if ($urandom_range(0, 1) == 1) op = 6'h00;
          else op = 6'($urandom_range(1, 63));
          while (is_legal(op, fn)) begin
            op = 6'($urandom_range(0, 63));
            fn = 6'($urandom_range(0, 63));
          end
          sq = {0,1};
        end
      endcase
      wr_reg = k inside {K_ADD, K_SUB, K_SLT, K_ADDI, K_XORI, K_LW, K_JAL};
      for (int i = 0; i < sq.size(); i++) begin
        bit last, z;
        last = (i == sq.size() - 1);
        z = 1'($urandom_range(0, 1));
        // The instruction register is only meaningful from DECODE on.
        if (i == 0) begin
          bus.Opcode = 6'($urandom_range(0, 63)); bus.Funct = 6'($urandom_range(0, 63));
        end else begin
          bus.Opcode = op; bus.Funct = fn;
        end
        bus.Zero = z;
        #1;
        chk("rnd_state", 32'(bus.State), 32'(sq[i]));
        chk("rnd_done", 32'(bus.InstrDone), 32'(last));
        chk("rnd_illegal", 32'(bus.IllegalOp), 32'(k == K_ILL && i == 1));
        chk("rnd_regwrite", 32'(bus.RegWrite), 32'(wr_reg && last));
        chk("rnd_memwrite", 32'(bus.MemWrite), 32'(k == K_SW && last));
        chk("rnd_irwrite", 32'(bus.IRWrite), 32'(i == 0));
        chk("rnd_abwrite", 32'(bus.ABWrite), 32'(i == 1));
        chk("rnd_pcwrite", 32'(bus.PCWrite),
            32'(i == 0 || (last && k inside {K_J, K_JAL, K_JR}) ||
                (last && k == K_BNE && !z)));
        @(posedge Clk); #1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
